// File: rtl/imm_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : imm_fetch_stage
// Purpose  : Registered decode stage feeding the MERC-16 immediate extenders.
//            Accepts 16-bit instruction words over valid/ready, classifies
//            them by opcode, extracts the 4/8/11-bit immediate field and
//            merges in upper bits from a preceding PREFIX instruction.
// Ports    :
//   Clock          in   rising-edge clock
//   Reset          in   asynchronous active-low reset
//   Flush          in   synchronous pipeline flush (drops entry and prefix)
//   InstrValid     in   upstream word valid
//   Instr[15:0]    in   instruction word, opcode in [15:12]
//   InstrReady     out  stage can accept a word this cycle
//   OutReady       in   downstream accepts the output entry this cycle
//   ImmValid       out  output register holds a valid entry
//   Opcode[3:0]    out  opcode of the output entry
//   ImmClass[1:0]  out  0 = 4-bit, 1 = 8-bit, 2 = 11-bit field
//   ImmRaw[15:0]   out  raw field, zero-filled above its MSB
//   Imm[15:0]      out  field with prefix bits merged in
//   Prefixed       out  output entry consumed a pending prefix
//   PrefixOverrun  out  sticky: PREFIX arrived while one was pending
// Revision : 1.0 - initial release
// ============================================================================
module imm_fetch_stage #(
  parameter logic [3:0] OPC_PREFIX     = 4'hF,
  parameter logic [3:0] OPC_8BIT_BASE  = 4'h8,
  parameter logic [3:0] OPC_11BIT_BASE = 4'hC
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Flush,
  input  logic        InstrValid,
  input  logic [15:0] Instr,
  output logic        InstrReady,
  input  logic        OutReady,
  output logic        ImmValid,
  output logic [3:0]  Opcode,
  output logic [1:0]  ImmClass,
  output logic [15:0] ImmRaw,
  output logic [15:0] Imm,
  output logic        Prefixed,
  output logic        PrefixOverrun
);

  typedef enum logic [0:0] {
    NO_PREFIX   = 1'b0,
    HAVE_PREFIX = 1'b1
  } pfx_state_t;

  localparam logic [1:0] C_CLASS_4  = 2'd0;
  localparam logic [1:0] C_CLASS_8  = 2'd1;
  localparam logic [1:0] C_CLASS_11 = 2'd2;

  pfx_state_t  state_q, state_d;
  logic [11:0] prefix_q, prefix_d;
  logic        valid_q, valid_d;
  logic [3:0]  opcode_q, opcode_d;
  logic [1:0]  class_q, class_d;
  logic [15:0] raw_q, raw_d;
  logic [15:0] imm_q, imm_d;
  logic        prefixed_q, prefixed_d;
  logic        overrun_q, overrun_d;

  logic        w_ready;
  logic        w_accept;
  logic        w_consume;
  logic        w_is_prefix;
  logic [3:0]  w_opc;
  logic [1:0]  w_class;
  logic [11:0] w_pfx;
  logic [15:0] w_raw;
  logic [15:0] w_imm;

  // Field decode of the incoming word; only registered values reach outputs.
  always_comb begin
    w_opc       = Instr[15:12];
    w_is_prefix = (w_opc == OPC_PREFIX);
    w_pfx       = (state_q == HAVE_PREFIX) ? prefix_q : 12'h000;

    if (w_opc >= OPC_11BIT_BASE) begin
      w_class = C_CLASS_11;
    end else if (w_opc >= OPC_8BIT_BASE) begin
      w_class = C_CLASS_8;
    end else begin
      w_class = C_CLASS_4;
    end

    case (w_class)
      C_CLASS_8: begin
        w_raw = {8'h00, Instr[7:0]};
        w_imm = {w_pfx[7:0], Instr[7:0]};
      end
      C_CLASS_11: begin
        // Instr[11] is not part of the 11-bit field.
        w_raw = {5'b00000, Instr[10:0]};
        w_imm = {w_pfx[4:0], Instr[10:0]};
      end
      default: begin
        w_raw = {12'h000, Instr[3:0]};
        w_imm = {w_pfx, Instr[3:0]};
      end
    endcase
  end

  // Flush gates ready so that it always wins over accept and consume.
  always_comb begin
    w_ready   = ~Flush & (~valid_q | OutReady);
    w_accept  = InstrValid & w_ready;
    w_consume = valid_q & OutReady;
  end

  always_comb begin
    state_d    = state_q;
    prefix_d   = prefix_q;
    valid_d    = valid_q;
    opcode_d   = opcode_q;
    class_d    = class_q;
    raw_d      = raw_q;
    imm_d      = imm_q;
    prefixed_d = prefixed_q;
    overrun_d  = overrun_q;

    if (Flush) begin
      valid_d  = 1'b0;
      state_d  = NO_PREFIX;
      prefix_d = 12'h000;
    end else if (w_accept && w_is_prefix) begin
      // A PREFIX produces no entry; the held entry only drains on consume.
      prefix_d = Instr[11:0];
      state_d  = HAVE_PREFIX;
      if (state_q == HAVE_PREFIX) begin
        overrun_d = 1'b1;
      end
      if (w_consume) begin
        valid_d = 1'b0;
      end
    end else if (w_accept) begin
      valid_d    = 1'b1;
      opcode_d   = w_opc;
      class_d    = w_class;
      raw_d      = w_raw;
      imm_d      = w_imm;
      prefixed_d = (state_q == HAVE_PREFIX);
      state_d    = NO_PREFIX;
    end else if (w_consume) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q    <= NO_PREFIX;
      prefix_q   <= 12'h000;
      valid_q    <= 1'b0;
      opcode_q   <= 4'h0;
      class_q    <= 2'd0;
      raw_q      <= 16'h0000;
      imm_q      <= 16'h0000;
      prefixed_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      prefix_q   <= prefix_d;
      valid_q    <= valid_d;
      opcode_q   <= opcode_d;
      class_q    <= class_d;
      raw_q      <= raw_d;
      imm_q      <= imm_d;
      prefixed_q <= prefixed_d;
      overrun_q  <= overrun_d;
    end
  end

  assign InstrReady    = w_ready;
  assign ImmValid      = valid_q;
  assign Opcode        = opcode_q;
  assign ImmClass      = class_q;
  assign ImmRaw        = raw_q;
  assign Imm           = imm_q;
  assign Prefixed      = prefixed_q;
  assign PrefixOverrun = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_imm_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_imm_fetch_stage
// Purpose  : Self-checking bench for imm_fetch_stage. Expected entries are
//            pushed to a queue when a word is accepted and compared when the
//            stage hands an entry downstream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imm_fetch_stage;

  typedef struct packed {
    logic [3:0]  opc;
    logic [1:0]  cls;
    logic [15:0] raw;
    logic [15:0] imm;
    logic        pfx;
  } ent_t;

  logic        clk = 1'b0;
  logic        Reset;
  logic        Flush;
  logic        InstrValid;
  logic [15:0] Instr;
  logic        InstrReady;
  logic        OutReady;
  logic        ImmValid;
  logic [3:0]  Opcode;
  logic [1:0]  ImmClass;
  logic [15:0] ImmRaw;
  logic [15:0] Imm;
  logic        Prefixed;
  logic        PrefixOverrun;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  ent_t sb[$];

  // Reference model of the prefix tracker.
  logic        m_pend = 1'b0;
  logic [11:0] m_preg = 12'h000;
  logic        m_ovr  = 1'b0;

  imm_fetch_stage dut (
    .Clock         (clk),
    .Reset         (Reset),
    .Flush         (Flush),
    .InstrValid    (InstrValid),
    .Instr         (Instr),
    .InstrReady    (InstrReady),
    .OutReady      (OutReady),
    .ImmValid      (ImmValid),
    .Opcode        (Opcode),
    .ImmClass      (ImmClass),
    .ImmRaw        (ImmRaw),
    .Imm           (Imm),
    .Prefixed      (Prefixed),
    .PrefixOverrun (PrefixOverrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic ent_t exp_of(input logic [15:0] w, input logic pend,
                                  input logic [11:0] preg);
    ent_t        e;
    logic [11:0] p;
    p     = pend ? preg : 12'h000;
    e.opc = w[15:12];
    e.pfx = pend;
    if (w[15:12] < 4'h8) begin
      e.cls = 2'd0;
      e.raw = {12'h000, w[3:0]};
      e.imm = {p, w[3:0]};
    end else if (w[15:12] < 4'hC) begin
      e.cls = 2'd1;
      e.raw = {8'h00, w[7:0]};
      e.imm = {p[7:0], w[7:0]};
    end else begin
      e.cls = 2'd2;
      e.raw = {5'b00000, w[10:0]};
      e.imm = {p[4:0], w[10:0]};
    end
    return e;
  endfunction

  // Update the model for a word the stage is accepting at the next edge.
  task automatic model_accept(input logic [15:0] w);
    if (w[15:12] == 4'hF) begin
      if (m_pend) m_ovr = 1'b1;
      m_pend = 1'b1;
      m_preg = w[11:0];
    end else begin
      sb.push_back(exp_of(w, m_pend, m_preg));
      m_pend = 1'b0;
    end
  endtask

  // Scoreboard: an entry leaves the stage when ImmValid & OutReady at an edge.
  always @(negedge clk) begin
    if (Reset && !Flush && ImmValid && OutReady) begin
      ent_t e_exp;
      ent_t e_act;
      e_act = '{Opcode, ImmClass, ImmRaw, Imm, Prefixed};
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected_entry: got %h, none expected (t=%0t)", e_act, $time);
      end else begin
        e_exp = sb.pop_front();
        if (e_act !== e_exp) begin
          n_fail++;
          $display("FAIL sb_entry: got opc=%h cls=%0d raw=%h imm=%h pfx=%b, expected opc=%h cls=%0d raw=%h imm=%h pfx=%b",
                   e_act.opc, e_act.cls, e_act.raw, e_act.imm, e_act.pfx,
                   e_exp.opc, e_exp.cls, e_exp.raw, e_exp.imm, e_exp.pfx);
        end
      end
    end
  end

  // Present a word and hold it until accepted (bounded), then drop valid.
  task automatic drive_word(input logic [15:0] w);
    int k;
    Instr      = w;
    InstrValid = 1'b1;
    k = 0;
    @(negedge clk);
    while (!InstrReady && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!InstrReady) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: word %h not accepted, InstrReady=%b required 1", w, InstrReady);
    end else begin
      model_accept(w);
    end
    @(posedge clk);
    #1;
    InstrValid = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b0; Flush = 1'b0; InstrValid = 1'b0; Instr = 16'h0000; OutReady = 1'b1;
    #2;
    n_checks++;
    if ({ImmValid, Opcode, ImmClass, ImmRaw, Imm, Prefixed, PrefixOverrun} !== 41'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%b opc=%h cls=%0d raw=%h imm=%h pfx=%b ovr=%b, required all 0",
               ImmValid, Opcode, ImmClass, ImmRaw, Imm, Prefixed, PrefixOverrun);
    end
    repeat (2) @(posedge clk);
    #1 Reset = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (ImmValid !== 1'b0 || InstrReady !== 1'b1 || Imm !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_idle: got ImmValid=%b InstrReady=%b Imm=%h, required 0/1/0000",
               ImmValid, InstrReady, Imm);
    end
  endtask

  task automatic test_stream();
    int c0;
    c0 = cyc;
    drive_word(16'h3ABC);
    n_checks++;
    if (ImmValid !== 1'b1 || ImmClass !== 2'd0 || Imm !== 16'h000C) begin
      n_fail++;
      $display("FAIL stream_4bit: got v=%b cls=%0d imm=%h, required 1/0/000C", ImmValid, ImmClass, Imm);
    end
    drive_word(16'h9ABC);
    n_checks++;
    if (ImmValid !== 1'b1 || ImmClass !== 2'd1 || Imm !== 16'h00BC) begin
      n_fail++;
      $display("FAIL stream_8bit: got v=%b cls=%0d imm=%h, required 1/1/00BC", ImmValid, ImmClass, Imm);
    end
    drive_word(16'hDABC);
    n_checks++;
    if (ImmValid !== 1'b1 || ImmClass !== 2'd2 || Imm !== 16'h02BC || ImmRaw !== 16'h02BC) begin
      n_fail++;
      $display("FAIL stream_11bit: got v=%b cls=%0d imm=%h raw=%h, required 1/2/02BC/02BC",
               ImmValid, ImmClass, Imm, ImmRaw);
    end
    n_checks++;
    if (cyc - c0 != 3) begin
      n_fail++;
      $display("FAIL stream_throughput: got %0d cycles for 3 words, required 3", cyc - c0);
    end
  endtask

  task automatic test_prefix_merge();
    drive_word(16'hF123);
    drive_word(16'h5004);
    n_checks++;
    if (Imm !== 16'h1234 || ImmRaw !== 16'h0004 || Prefixed !== 1'b1) begin
      n_fail++;
      $display("FAIL prefix_4bit: got imm=%h raw=%h pfx=%b, required 1234/0004/1", Imm, ImmRaw, Prefixed);
    end
    drive_word(16'hF0A5);
    drive_word(16'hC7FF);
    n_checks++;
    if (Imm !== 16'h2FFF || ImmRaw !== 16'h07FF || Prefixed !== 1'b1) begin
      n_fail++;
      $display("FAIL prefix_11bit: got imm=%h raw=%h pfx=%b, required 2FFF/07FF/1", Imm, ImmRaw, Prefixed);
    end
  endtask

  task automatic test_backpressure();
    int bad;
    @(posedge clk); #1;
    OutReady = 1'b0;
    drive_word(16'h1055);
    Instr      = 16'h9066;
    InstrValid = 1'b1;
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (InstrReady !== 1'b0 || ImmValid !== 1'b1 || Imm !== 16'h0005 || Opcode !== 4'h1) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL backpressure_hold: %0d bad cycles (last ready=%b v=%b imm=%h), required ready=0 v=1 imm=0005",
               bad, InstrReady, ImmValid, Imm);
    end
    @(posedge clk); #1;
    OutReady = 1'b1;
    @(negedge clk);
    n_checks++;
    if (InstrReady !== 1'b1) begin
      n_fail++;
      $display("FAIL backpressure_release_ready: got InstrReady=%b, required 1", InstrReady);
    end else begin
      model_accept(16'h9066);
    end
    @(posedge clk); #1;
    InstrValid = 1'b0;
    n_checks++;
    if (ImmValid !== 1'b1 || Imm !== 16'h0066) begin
      n_fail++;
      $display("FAIL backpressure_replace: got v=%b imm=%h, required 1/0066", ImmValid, Imm);
    end
  endtask

  task automatic test_double_prefix();
    drive_word(16'hF111);
    n_checks++;
    if (PrefixOverrun !== 1'b0) begin
      n_fail++;
      $display("FAIL overrun_early: got %b, required 0", PrefixOverrun);
    end
    drive_word(16'hF222);
    drive_word(16'h0003);
    n_checks++;
    if (PrefixOverrun !== 1'b1 || Imm !== 16'h2223 || Prefixed !== 1'b1) begin
      n_fail++;
      $display("FAIL double_prefix: got ovr=%b imm=%h pfx=%b, required 1/2223/1", PrefixOverrun, Imm, Prefixed);
    end
    drive_word(16'h0001);
    n_checks++;
    if (PrefixOverrun !== m_ovr || Prefixed !== 1'b0) begin
      n_fail++;
      $display("FAIL overrun_sticky: got ovr=%b pfx=%b, required %b/0", PrefixOverrun, Prefixed, m_ovr);
    end
  endtask

  task automatic test_flush();
    drive_word(16'hF0AA);
    Instr      = 16'h1234;
    InstrValid = 1'b1;
    Flush      = 1'b1;
    @(negedge clk);
    n_checks++;
    if (InstrReady !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_ready: got InstrReady=%b, required 0", InstrReady);
    end
    @(posedge clk); #1;
    Flush      = 1'b0;
    InstrValid = 1'b0;
    m_pend     = 1'b0;
    n_checks++;
    if (ImmValid !== 1'b0 || PrefixOverrun !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_clear: got v=%b ovr=%b, required 0/1", ImmValid, PrefixOverrun);
    end
    drive_word(16'h0007);
    n_checks++;
    if (Imm !== 16'h0007 || Prefixed !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_prefix_drop: got imm=%h pfx=%b, required 0007/0", Imm, Prefixed);
    end
  endtask

  task automatic test_random();
    logic [15:0] w;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) w = {4'hF, 12'($urandom)};
      else                           w = {4'($urandom_range(0, 14)), 12'($urandom)};
      drive_word(w);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL random_drain: %0d entries never produced, required 0", sb.size());
    end
  endtask

  task automatic test_async_reset();
    OutReady = 1'b0;
    drive_word(16'hF00F);
    drive_word(16'h2009);
    #3 Reset = 1'b0;
    #1;
    n_checks++;
    if ({ImmValid, Opcode, ImmClass, ImmRaw, Imm, Prefixed, PrefixOverrun} !== 41'd0) begin
      n_fail++;
      $display("FAIL async_reset: got v=%b opc=%h cls=%0d raw=%h imm=%h pfx=%b ovr=%b, required all 0",
               ImmValid, Opcode, ImmClass, ImmRaw, Imm, Prefixed, PrefixOverrun);
    end
    sb.delete();
    m_pend = 1'b0;
    m_preg = 12'h000;
    m_ovr  = 1'b0;
    @(posedge clk); #1;
    Reset    = 1'b1;
    OutReady = 1'b1;
    @(posedge clk); #1;
    drive_word(16'h0001);
    n_checks++;
    if (Imm !== 16'h0001 || Prefixed !== 1'b0 || PrefixOverrun !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_prefix_cleared: got imm=%h pfx=%b ovr=%b, required 0001/0/0", Imm, Prefixed, PrefixOverrun);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_prefix_merge();
    test_backpressure();
    test_double_prefix();
    test_flush();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/imm_fetch_stage.md
Name: imm_fetch_stage

Overview:
- Registered decode stage directly upstream of the immediate zero extender in the MERC-16 datapath.
- Accepts 16-bit instruction words over a valid/ready handshake and classifies each by opcode.
- Extracts the 4-, 8- or 11-bit immediate field and presents a registered 16-bit immediate to the extenders and ALU operand mux.
- Handles a PREFIX instruction that supplies the upper immediate bits for the next instruction, so every class can form a full 16-bit immediate.

Parameters:
- OPC_PREFIX, 4'hF, opcode value of the PREFIX instruction.
- OPC_8BIT_BASE, 4'h8, lowest opcode of the 8-bit immediate class. Opcodes below this are 4-bit class.
- OPC_11BIT_BASE, 4'hC, lowest opcode of the 11-bit class. Opcodes from here up to OPC_PREFIX-1 are 11-bit class.

Ports:
- Clock  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-low reset.
- Flush  in  1  synchronous pipeline flush.
- InstrValid  in  1  upstream word valid.
- Instr  in  16  instruction word. Opcode is Instr[15:12].
- InstrReady  out  1  stage can accept a word this cycle.
- OutReady  in  1  downstream accepts the output this cycle.
- ImmValid  out  1  output register holds a valid entry.
- Opcode  out  4  opcode of the output entry.
- ImmClass  out  2  class of the output entry: 0 = 4-bit, 1 = 8-bit, 2 = 11-bit.
- ImmRaw  out  16  raw field, zero-filled above the field MSB (input to the zero extender).
- Imm  out  16  field with prefix bits merged in.
- Prefixed  out  1  output entry consumed a pending prefix.
- PrefixOverrun  out  1  sticky flag: a PREFIX arrived while a prefix was already pending.

Behaviour:
- Reset asserted (Reset=0), asynchronously:
  - ImmValid=0; Opcode, ImmClass, ImmRaw and Imm are 0.
  - Prefixed=0 and PrefixOverrun=0.
  - Prefix state returns to NO_PREFIX and the prefix register is cleared.
  - Reset mid-transfer discards all in-flight data.
- Handshake:
  - InstrReady = ~Flush & (~ImmValid | OutReady).
  - A word is accepted when InstrValid & InstrReady are high at a rising edge.
  - The output entry is consumed when ImmValid & OutReady are high.
- Latency:
  - A non-prefix word accepted at edge N appears at the outputs after edge N with ImmValid=1.
  - One entry of buffering; no combinational path from Instr to the outputs.
- ImmValid update at each edge:
  - Set if a non-prefix word is accepted.
  - Otherwise cleared if the entry is consumed.
  - Otherwise held.
  - Output fields hold their value while ImmValid=1 and OutReady=0.
- State machine (prefix tracking):
  - NO_PREFIX, PREFIX accepted: capture Instr[11:0] into the prefix register, go to HAVE_PREFIX. No output entry; ImmValid follows the consume rule.
  - HAVE_PREFIX, PREFIX accepted: overwrite the prefix register, set PrefixOverrun, stay in HAVE_PREFIX.
  - HAVE_PREFIX, non-prefix accepted: merge the prefix, set Prefixed=1, go to NO_PREFIX.
  - NO_PREFIX, non-prefix accepted: upper Imm bits are 0, Prefixed=0.
- Field extraction (P = prefix register, or 0 in NO_PREFIX):
  - 4-bit class: ImmRaw={12'b0,Instr[3:0]}, Imm={P[11:0],Instr[3:0]}.
  - 8-bit class: ImmRaw={8'b0,Instr[7:0]}, Imm={P[7:0],Instr[7:0]}.
  - 11-bit class: ImmRaw={5'b0,Instr[10:0]}, Imm={P[4:0],Instr[10:0]}. Instr[11] is ignored.
  - With no prefix, Imm==ImmRaw.
- Flush=1 at an edge:
  - ImmValid cleared and state goes to NO_PREFIX.
  - InstrReady=0, so no word is accepted that edge; flush beats simultaneous accept and consume.
  - PrefixOverrun is unaffected; only Reset clears it.
- Simultaneous accept and consume in the same edge:
  - The new entry replaces the old one; ImmValid stays 1.
  - Full throughput is one word per clock.
- Backpressure with PREFIX:
  - A PREFIX can be accepted only while InstrReady=1.
  - It never disturbs a held output entry.

Test Plan:
- Reset low, then high, no stimulus -> ImmValid=0, InstrReady=1, all outputs 0. Assert Reset mid-stream -> outputs clear immediately, without waiting for a clock edge.
- Stream 16'h3ABC, 16'h9ABC, 16'hDABC with OutReady=1:
  - First entry: ImmClass=0, Imm=16'h000C.
  - Second entry: ImmClass=1, Imm=16'h00BC.
  - Third entry: ImmClass=2, Imm=16'h02BC.
  - One entry per cycle, 1-cycle latency.
- Prefix merge: 16'hF123 then 16'h5004 -> Imm=16'h1234, ImmRaw=16'h0004, Prefixed=1. Then 16'hF0A5 followed by 16'hC7FF -> Imm=16'h2FFF.
- Backpressure: hold OutReady=0 with ImmValid=1 -> InstrReady=0 and outputs stable. Release OutReady -> the next word is accepted on the same edge, ImmValid stays 1.
- Double prefix 16'hF111, 16'hF222, 16'h0003 -> PrefixOverrun=1 (sticky), Imm=16'h2223.
- Flush with a pending prefix and InstrValid=1 -> word dropped, ImmValid=0. Then 16'h0007 -> Imm=16'h0007, Prefixed=0.
